// File: rtl/product_accumulator_pkg.sv
`default_nettype none
// ==========================================================================
// product_accumulator_pkg : FSM state encoding and default widths
// Rev 1.0
// ==========================================================================
package product_accumulator_pkg;

  localparam int DEFAULT_ACC_W = 12;
  localparam int DEFAULT_LEN_W = 4;
  localparam int PRODUCT_W     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/product_accumulator_if.sv
`default_nettype none
// ==========================================================================
// product_accumulator_if : burst control, product input and result handshake
// Rev 1.0
// ==========================================================================
interface product_accumulator_if
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W = DEFAULT_ACC_W,
  parameter int LEN_W = DEFAULT_LEN_W
);

  logic                 start;
  logic [LEN_W-1:0]     len;
  logic                 in_valid;
  logic [PRODUCT_W-1:0] in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [ACC_W-1:0]     out_data;
  logic                 out_ovf;
  logic                 out_ready;
  logic                 busy;

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, busy
  );

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf, busy
  );

endinterface
`default_nettype wire

// File: rtl/product_accumulator_acc_adder.sv
`default_nettype none
// ==========================================================================
// acc_adder : ACC_W-bit adder with carry-out for the accumulator datapath
// Rev 1.0
// ==========================================================================
module acc_adder
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W = DEFAULT_ACC_W
) (
  input  wire logic [ACC_W-1:0] a,
  input  wire logic [ACC_W-1:0] b,
  output logic      [ACC_W-1:0] sum,
  output logic                  carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule
`default_nettype wire

// File: rtl/product_accumulator.sv
`default_nettype none
// ==========================================================================
// product_accumulator : sums a burst of len 8-bit products, sticky overflow
// Rev 1.0
// ==========================================================================
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W = DEFAULT_ACC_W,
  parameter int LEN_W = DEFAULT_LEN_W
) (
  input wire logic              clk,
  input wire logic              rstn,
  product_accumulator_if.slave  bus
);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic             ovf, ovf_nxt;
  logic [LEN_W-1:0] count, count_nxt;

  logic [ACC_W-1:0] data_ext;
  logic [ACC_W-1:0] sum;
  logic             carry;

  assign data_ext = ACC_W'(bus.in_data);

  acc_adder #(.ACC_W(ACC_W)) u_acc_adder (
    .a     (acc),
    .b     (data_ext),
    .sum   (sum),
    .carry (carry)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      count <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      ovf   <= ovf_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    ovf_nxt   = ovf;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (bus.start) begin
          acc_nxt = '0;
          ovf_nxt = 1'b0;
          if (bus.len != '0) begin
            state_nxt = ACCUM;
            count_nxt = bus.len;
          end else begin
            state_nxt = DONE;
            count_nxt = '0;
          end
        end
      end
      ACCUM: begin
        if (bus.in_valid) begin
          acc_nxt   = sum;
          ovf_nxt   = ovf | carry;
          count_nxt = count - LEN_W'(1);
          // Last product moves straight to DONE so out_valid follows next cycle
          if (count == LEN_W'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs come from state and registers only; in_data never reaches a port
  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_data  = acc;
  assign bus.out_ovf   = ovf;

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ==========================================================================
// tb_product_accumulator : directed bursts with a result scoreboard
// Rev 1.0
// ==========================================================================
module tb_product_accumulator;
  import product_accumulator_pkg::*;

  typedef struct {
    int data;
    int ovf;
  } res_t;

  logic clk = 1'b0;
  logic rstn;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   t0     = 0;
  int   exp_acc;
  int   exp_ovf;
  int   lat;
  res_t sb[$];

  product_accumulator_if #(.ACC_W(DEFAULT_ACC_W), .LEN_W(DEFAULT_LEN_W)) bus ();
  product_accumulator_if #(.ACC_W(8), .LEN_W(DEFAULT_LEN_W)) bus8 ();

  product_accumulator #(.ACC_W(DEFAULT_ACC_W), .LEN_W(DEFAULT_LEN_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  product_accumulator #(.ACC_W(8), .LEN_W(DEFAULT_LEN_W)) dut8 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic begin_burst(input logic [3:0] l);
    bus.start = 1'b1;
    bus.len   = l;
    exp_acc   = 0;
    exp_ovf   = 0;
    t0        = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] d, input int bubbles);
    int n;
    int s;
    for (int i = 0; i < bubbles; i++) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("in_ready_bubble", 32'(bus.in_ready), 1);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_accept", 32'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    s = exp_acc + int'(d);
    if (s > (1 << DEFAULT_ACC_W) - 1) exp_ovf = 1;
    exp_acc = s & ((1 << DEFAULT_ACC_W) - 1);
  endtask

  task automatic end_burst();
    res_t r;
    r.data = exp_acc;
    r.ovf  = exp_ovf;
    sb.push_back(r);
  endtask

  task automatic wait_result(input string tag, input int hold, output int latency);
    int   n;
    res_t r;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    latency = cyc - t0;
    check({tag, "_out_valid"}, 32'(bus.out_valid), 1);
    check({tag, "_sb_pending"}, 32'(sb.size()), 1);
    r.data = -1;
    r.ovf  = -1;
    if (sb.size() != 0) r = sb.pop_front();
    check({tag, "_data"}, 32'(bus.out_data), 32'(r.data));
    check({tag, "_ovf"}, 32'(bus.out_ovf), 32'(r.ovf));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 1);
      check({tag, "_hold_data"}, 32'(bus.out_data), 32'(r.data));
      check({tag, "_hold_ovf"}, 32'(bus.out_ovf), 32'(r.ovf));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_after_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_after_busy"}, 32'(bus.busy), 0);
    check({tag, "_after_data"}, 32'(bus.out_data), 32'(r.data));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_out_data"}, 32'(bus.out_data), 0);
    check({tag, "_out_ovf"}, 32'(bus.out_ovf), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
  endtask

  initial begin
    rstn           = 1'b0;
    bus.start      = 1'b0;
    bus.len        = '0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus8.start     = 1'b0;
    bus8.len       = '0;
    bus8.in_valid  = 1'b0;
    bus8.in_data   = '0;
    bus8.out_ready = 1'b0;

    @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Four maximal products back-to-back
    begin_burst(4'd4);
    for (int i = 0; i < 4; i++) feed(8'd225, 0);
    end_burst();
    wait_result("sum900", 0, lat);
    check("sum900_latency", 32'(lat), 5);

    // Bubbles between products
    begin_burst(4'd3);
    feed(8'd10, 0);
    feed(8'd0, 2);
    feed(8'd7, 2);
    end_burst();
    wait_result("sum17", 0, lat);

    // 8-bit accumulator overflow: 200 + 100 wraps to 44
    bus8.start = 1'b1;
    bus8.len   = 4'd2;
    @(negedge clk);
    bus8.start = 1'b0;
    check("w8_in_ready", 32'(bus8.in_ready), 1);
    bus8.in_valid = 1'b1;
    bus8.in_data  = 8'd200;
    @(negedge clk);
    bus8.in_data  = 8'd100;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    check("w8_out_valid", 32'(bus8.out_valid), 1);
    check("w8_data", 32'(bus8.out_data), 44);
    check("w8_ovf", 32'(bus8.out_ovf), 1);
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.out_ready = 1'b0;
    check("w8_after_valid", 32'(bus8.out_valid), 0);

    // Zero-length burst, result held while consumer stalls
    begin_burst(4'd0);
    end_burst();
    wait_result("len0", 3, lat);
    check("len0_latency", 32'(lat), 1);

    // start pulses during ACCUM and DONE must be ignored
    begin_burst(4'd2);
    feed(8'd50, 0);
    bus.start = 1'b1;
    bus.len   = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    feed(8'd60, 0);
    end_burst();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_result("ignore", 1, lat);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ignore_idle_valid", 32'(bus.out_valid), 0);
      check("ignore_idle_busy", 32'(bus.busy), 0);
    end

    // Reset mid-burst abandons it
    begin_burst(4'd5);
    feed(8'd100, 0);
    feed(8'd100, 0);
    check("pre_rst_data", 32'(bus.out_data), 200);
    rstn = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_all_zero("post_rst");
    begin_burst(4'd1);
    feed(8'd9, 0);
    end_burst();
    wait_result("fresh9", 0, lat);
    check("fresh9_latency", 32'(lat), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
